spongent_msg_ctrl: RTL
======================

// Module: spongent_msg_ctrl
// PURPOSE
//  Sequencer between a word-stream message source and one spongent_iter hash core.
//  - Resets the core per message; feeds r-bit words via data_ready strobes.
//  - Optionally appends the padding word, fires start_hash, captures the N-bit digest.
//  - Hands the digest downstream with a valid/ready handshake; a watchdog flags hung core handshakes.
// PARAMETERS
//  N         88      digest width (bits)
//  r         8       rate: message word width (bits)
//  TIMEOUT   1024    max cycles waiting on core busy/end_hash before error; >=2, counter $clog2(TIMEOUT+1) bits
// PORTS
//  clk          in   1   single clock
//  rst          in   1   synchronous, active-high reset
//  msg_valid    in   1   msg_data/msg_last valid
//  msg_ready    out  1   controller accepts word this cycle (valid&ready = transfer)
//  msg_data     in   r   message word
//  msg_last     in   1   final word of message
//  dig_valid    out  1   digest available
//  dig_ready    in   1   downstream accepts digest
//  digest_o     out  N   registered digest
//  err_o        out  1   sticky watchdog error; cleared only by rst
//  core_rst     out  1   to core rst
//  core_din     out  r   to core data_input (registered)
//  core_dready  out  1   to core data_ready (1-cycle strobe)
//  core_start   out  1   to core start_hash (1-cycle strobe)
//  core_busy    in   1   from core busy
//  core_end     in   1   from core end_hash
//  core_digest  in   N   from core digest
// BEHAVIOUR
//  Reset: state=IDLE; msg_ready=0, dig_valid=0, digest_o=0, err_o=0, core_rst=1, core_din=0, core_dready=0, core_start=0.
//  FSM states and transitions:
//   IDLE    : core_rst=1. msg_valid=1 -> CRST.
//   CRST    : core_rst=1 for exactly one more cycle, then 0 -> FEED.
//   FEED    : msg_ready=1 iff !core_busy. On transfer: core_din<=msg_data, core_dready=1 next cycle, last_q<=msg_last -> GUARD.
//   GUARD   : one cycle, no strobes; lets core raise busy -> ABSORB.
//   ABSORB  : wait core_busy==0.
//             !last_q -> FEED.
//             last_q -> PAD (PAD_EN) or START.
//   PAD     : core_din<=pad word, core_dready=1 next cycle, last_q<=0 -> GUARD2 -> ABSORB2; busy low -> START.
//             pad word = MSB 1, rest 0 (r=8: 8'h80).
//   START   : core_start=1 for one cycle -> SQUEEZE.
//   SQUEEZE : wait core_end==1; digest_o<=core_digest same edge -> DONE.
//   DONE    : dig_valid=1; digest_o held stable. dig_valid&dig_ready -> IDLE (dig_valid=0 next cycle).
//             msg_ready=0 throughout DONE.
//  Strobes: core_dready and core_start never high together; each high exactly one cycle per event.
//  Latency: msg_ready never asserted outside FEED; at most one word per core absorb.
//  Watchdog: counter clears on every state change.
//   - Counts in ABSORB/ABSORB2/SQUEEZE; reaching TIMEOUT -> err_o=1, state->IDLE.
//   - Aborted message dropped, dig_valid stays 0.
//  Boundaries:
//   - Zero-length messages not supported; the first accepted word begins the message.
//   - msg_last on first word: single-word message, legal.
//   - core_end while not in SQUEEZE: ignored.
//   - core_busy high in FEED: msg_ready held 0, no word lost.
//   - dig_ready high before dig_valid: no effect.
//   - rst mid-message: all state discarded, core_rst reasserted; partial message lost.
// CONFIGURATION
//  SPONGENT_CTRL_PAD_EN defined: controller appends pad word after last message word (PAD path).
//  Undefined: PAD/GUARD2/ABSORB2 removed; upstream supplies padded stream; ABSORB with last_q -> START.
// TESTING
//  1 Reset: rst=1 3 cycles -> all outputs at reset values, core_rst=1, msg_ready=0.
//  2 Single word 8'h61 last=1, PAD_EN, core model busy 3 cycles/word, end after 10 cycles ->
//    core sees dready words 61,80 then one start; digest_o=model digest; dig_valid until dig_ready.
//  3 Five-word msg with msg_valid gaps and dig_ready held 0 for 20 cycles ->
//    exactly 5 (+1 pad) dready strobes, none while busy; digest_o stable through DONE.
//  4 Core model never deasserts busy, TIMEOUT=16 -> err_o=1 at cycle 16 of ABSORB, FSM IDLE, dig_valid=0.
//  5 rst pulsed mid FEED after 2 words, then new 1-word msg -> core_rst re-pulsed, only new msg hashed.
//  6 PAD_EN undefined, 2 words 61,62 -> exactly 2 dready strobes then core_start; no 8'h80 word sent.

Source files
------------

// File: rtl/spongent_msg_ctrl_if.sv
// Message-in / digest-out handshake bundle for spongent_msg_ctrl.
// The master is the upstream/downstream side; the slave is the controller.
interface spongent_msg_ctrl_if #(
  parameter int N = 88,
  parameter int r = 8
);
  logic         msg_valid;
  logic         msg_ready;
  logic [r-1:0] msg_data;
  logic         msg_last;
  logic         dig_valid;
  logic         dig_ready;
  logic [N-1:0] digest_o;

  modport master (
    output msg_valid, msg_data, msg_last, dig_ready,
    input  msg_ready, dig_valid, digest_o
  );

  modport slave (
    input  msg_valid, msg_data, msg_last, dig_ready,
    output msg_ready, dig_valid, digest_o
  );
endinterface

// File: rtl/spongent_msg_ctrl.sv
// Word-stream sequencer for one spongent_iter core: reset, absorb, squeeze, hand off digest.
// Define SPONGENT_CTRL_PAD_EN to have the controller append the pad word itself.
module spongent_msg_ctrl #(
  parameter int N       = 88,
  parameter int r       = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  spongent_msg_ctrl_if.slave  bus,
  output logic                err_o,
  output logic                core_rst,
  output logic [r-1:0]        core_din,
  output logic                core_dready,
  output logic                core_start,
  input  logic                core_busy,
  input  logic                core_end,
  input  logic [N-1:0]        core_digest
);

  // state   | meaning
  // IDLE    | core held in reset, waiting for first word
  // CRST    | one extra core reset cycle
  // FEED    | accept one message word when core idle
  // GUARD   | dready strobe cycle, core raises busy
  // ABSORB  | wait for core to finish absorbing
  // PAD     | issue pad word (pad build only)
  // GUARD2  | pad dready strobe cycle
  // ABSORB2 | wait for pad absorb
  // START   | start_hash strobe cycle
  // SQUEEZE | wait for end_hash, capture digest
  // DONE    | digest offered downstream
  typedef enum logic [3:0] {
    IDLE, CRST, FEED, GUARD, ABSORB, START, SQUEEZE, DONE
`ifdef SPONGENT_CTRL_PAD_EN
    , PAD, GUARD2, ABSORB2
`endif
  } state_t;

  localparam int             WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT - 1);
`ifdef SPONGENT_CTRL_PAD_EN
  localparam logic [r-1:0]   PAD_WORD = {1'b1, {(r-1){1'b0}}};
`endif

  state_t         state;
  logic           last_q;
  logic [WDW-1:0] wd_cnt;
  logic           dig_valid_q;
  logic [N-1:0]   digest_q;
  logic           err_q;
  logic           xfer;

  assign bus.msg_ready = (state == FEED) && !core_busy;
  assign bus.dig_valid = dig_valid_q;
  assign bus.digest_o  = digest_q;
  assign err_o         = err_q;
  assign xfer          = bus.msg_valid && bus.msg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_q      <= 1'b0;
      wd_cnt      <= WD_LOAD;
      dig_valid_q <= 1'b0;
      digest_q    <= '0;
      err_q       <= 1'b0;
      core_rst    <= 1'b1;
      core_din    <= '0;
      core_dready <= 1'b0;
      core_start  <= 1'b0;
    end else begin
      core_dready <= 1'b0;
      core_start  <= 1'b0;
      // Reloaded every cycle outside the wait states, so any state change clears it.
      wd_cnt      <= WD_LOAD;
      case (state)
        IDLE: begin
          core_rst <= 1'b1;
          if (bus.msg_valid) state <= CRST;
        end
        CRST: begin
          core_rst <= 1'b0;
          state    <= FEED;
        end
        FEED: begin
          if (xfer) begin
            core_din    <= bus.msg_data;
            core_dready <= 1'b1;
            last_q      <= bus.msg_last;
            state       <= GUARD;
          end
        end
        GUARD: state <= ABSORB;
        ABSORB: begin
          if (!core_busy) begin
            if (!last_q) begin
              state <= FEED;
            end else begin
`ifdef SPONGENT_CTRL_PAD_EN
              state <= PAD;
`else
              core_start <= 1'b1;
              state      <= START;
`endif
            end
          end else if (wd_cnt == '0) begin
            err_q    <= 1'b1;
            core_rst <= 1'b1;
            state    <= IDLE;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
`ifdef SPONGENT_CTRL_PAD_EN
        PAD: begin
          core_din    <= PAD_WORD;
          core_dready <= 1'b1;
          last_q      <= 1'b0;
          state       <= GUARD2;
        end
        GUARD2: state <= ABSORB2;
        ABSORB2: begin
          if (!core_busy) begin
            core_start <= 1'b1;
            state      <= START;
          end else if (wd_cnt == '0) begin
            err_q    <= 1'b1;
            core_rst <= 1'b1;
            state    <= IDLE;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
`endif
        START: state <= SQUEEZE;
        SQUEEZE: begin
          if (core_end) begin
            digest_q    <= core_digest;
            dig_valid_q <= 1'b1;
            state       <= DONE;
          end else if (wd_cnt == '0) begin
            err_q    <= 1'b1;
            core_rst <= 1'b1;
            state    <= IDLE;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.dig_ready) begin
            dig_valid_q <= 1'b0;
            core_rst    <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          core_rst <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
